stopwatch_display: RTL

//   Downstream stage of the stopwatch minute/second counter: takes binary minutes/seconds and drives a
//   4-digit multiplexed 7-segment display as MM.SS. Frame-coherent snapshot of the inputs (no tearing
//   mid-scan), binary-to-decimal split, digit scan with inter-digit blanking (anti-ghosting), registered pins.

---
 rtl/stopwatch_display.sv | 132 +++++++++++++
 1 files changed

// File: rtl/stopwatch_display.sv
// Multiplexed 4-digit 7-segment driver for a MM.SS stopwatch readout.
// Frame-coherent input snapshot, per-slot anti-ghost blanking, registered pins.
module stopwatch_display #(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter int unsigned COMMON_ANODE = 1,
   parameter int unsigned LZ_BLANK     = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       colon_en,
   output logic [3:0] anode,
   output logic [6:0] segments,
   output logic       dp
);

   localparam int unsigned PW      = $clog2(REFRESH_DIV);
   localparam logic        INV     = (COMMON_ANODE != 0);
   localparam logic        LZ      = (LZ_BLANK != 0);
   localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

   logic [PW-1:0] prescaler;
   logic [1:0]    idx;
   logic [5:0]    snap_min;
   logic [5:0]    snap_sec;

   logic          frame_start_c;
   logic          blank_c;
   logic          lz_hide_c;
   logic [3:0]    sec_tens_c, sec_ones_c, min_tens_c, min_ones_c;
   logic [3:0]    digit_c;
   logic [3:0]    anode_c;
   logic [6:0]    seg_c;
   logic          dp_c;

   // Tens digit of a 0..63 value by threshold compare (no divider).
   function automatic logic [3:0] tens_of(input logic [5:0] v);
      if      (v >= 6'd60) return 4'd6;
      else if (v >= 6'd50) return 4'd5;
      else if (v >= 6'd40) return 4'd4;
      else if (v >= 6'd30) return 4'd3;
      else if (v >= 6'd20) return 4'd2;
      else if (v >= 6'd10) return 4'd1;
      else                 return 4'd0;
   endfunction

   function automatic logic [3:0] ones_of(input logic [5:0] v, input logic [3:0] t);
      logic [5:0] base;
      base = 6'({2'b00, t}) * 6'd10;
      return 4'(v - base);
   endfunction

   // Active-high gfedcba pattern.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Next pin values, active-high, from current scan state.
   always_comb begin
      frame_start_c = (prescaler == '0) && (idx == 2'd0);
      blank_c       = (prescaler < P_BLANK);
      sec_tens_c    = tens_of(snap_sec);
      sec_ones_c    = ones_of(snap_sec, sec_tens_c);
      min_tens_c    = tens_of(snap_min);
      min_ones_c    = ones_of(snap_min, min_tens_c);
      case (idx)
         2'd0:    digit_c = sec_ones_c;
         2'd1:    digit_c = sec_tens_c;
         2'd2:    digit_c = min_ones_c;
         default: digit_c = min_tens_c;
      endcase
      lz_hide_c = LZ && (idx == 2'd3) && (min_tens_c == 4'd0);
      anode_c   = 4'b0000;
      seg_c     = 7'h00;
      dp_c      = 1'b0;
      if (!blank_c && !lz_hide_c) begin
         anode_c = 4'b0001 << idx;
         seg_c   = seg7(digit_c);
         dp_c    = (idx == 2'd2) && colon_en;
      end
   end

   // Scan counters and frame snapshot.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
         idx       <= 2'd0;
         snap_min  <= 6'd0;
         snap_sec  <= 6'd0;
      end else begin
         if (prescaler == P_LAST) begin
            prescaler <= '0;
            idx       <= idx + 2'd1;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
         if (frame_start_c) begin
            snap_min <= minutes;
            snap_sec <= seconds;
         end
      end
   end

   // Registered pins with polarity applied.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         anode    <= {4{INV}};
         segments <= {7{INV}};
         dp       <= INV;
      end else begin
         anode    <= anode_c ^ {4{INV}};
         segments <= seg_c ^ {7{INV}};
         dp       <= dp_c ^ INV;
      end
   end

endmodule
